// File: rtl/simon_sequencer.sv
// Simon game controller: grows an LFSR-drawn colour pattern, plays it back, then checks the player's replay.
// Optional input timeout in WAIT_IN is enabled by defining SIMON_TIMEOUT_EN.
`timescale 1ns/1ps
module simon_sequencer #(
  parameter int          MAX_LEN     = 16,
  parameter int          SHOW_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 12500000,
  parameter int          TIMEOUT_CYC = 250000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          key_valid,
  input  logic [1:0]    color_in,
  output logic          show_valid,
  output logic [1:0]    show_color,
  output logic [LW-1:0] level,
  output logic          awaiting_input,
  output logic          win,
  output logic          lose,
  output logic [2:0]    state_dbg
);

  // Handshake: start and key_valid are single-cycle strobes with no ready; they are acted on
  // only in the states that accept them and silently dropped everywhere else.

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Timer is sized to the longest reload value it may ever hold.
  localparam int TMAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0] WAIT_LD = TW'(TIMEOUT_CYC - 1);
`else
  localparam logic [TW-1:0] WAIT_LD = '0;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADD      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_WIN      = 3'd5;
  localparam logic [2:0] S_LOSE     = 3'd6;

  logic [2:0]    state;
  logic [LW-1:0] idx;
  logic [TW-1:0] timer;
  logic [15:0]   lfsr;
  logic [1:0]    ram [0:(1<<AW)-1];

  logic       lfsr_fb;
  logic       last_step;
  logic       key_match;
  logic       timer_zero;
  logic [1:0] ram_rd;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign ram_rd     = ram[idx[AW-1:0]];
  assign last_step  = (idx == level - LW'(1));
  assign key_match  = (color_in == ram_rd);
  assign timer_zero = (timer == '0);

  // Pattern storage is deliberately not reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (!reset && state == S_ADD) begin
      ram[level[AW-1:0]] <= lfsr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      level <= '0;
      idx   <= '0;
      timer <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state <= S_ADD;
            level <= '0;
            timer <= '0;
          end
        end
        S_ADD: begin
          level <= level + LW'(1);
          idx   <= '0;
          state <= S_SHOW_ON;
          timer <= SHOW_LD;
        end
        S_SHOW_ON: begin
          if (timer_zero) begin
            state <= S_SHOW_OFF;
            timer <= GAP_LD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (!timer_zero) begin
            timer <= timer - TW'(1);
          end else if (last_step) begin
            state <= S_WAIT_IN;
            idx   <= '0;
            timer <= WAIT_LD;
          end else begin
            state <= S_SHOW_ON;
            idx   <= idx + LW'(1);
            timer <= SHOW_LD;
          end
        end
        S_WAIT_IN: begin
          if (key_valid) begin
            if (!key_match) begin
              state <= S_LOSE;
              timer <= '0;
            end else if (last_step) begin
              state <= (level == LW'(MAX_LEN)) ? S_WIN : S_ADD;
              timer <= '0;
            end else begin
              idx   <= idx + LW'(1);
              timer <= WAIT_LD;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (timer_zero) begin
            state <= S_LOSE;
          end else begin
            timer <= timer - TW'(1);
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    show_valid     = (state == S_SHOW_ON);
    show_color     = show_valid ? ram_rd : 2'b00;
    awaiting_input = (state == S_WAIT_IN);
    win            = (state == S_WIN);
    lose           = (state == S_LOSE);
    state_dbg      = state;
  end

endmodule
